// File: rtl/tx_bram_reader.sv
// ---------------------------------------------------------------------------
// tx_bram_reader
//
// Plays a run of samples out of a dual-port block RAM onto a valid/ready
// stream. A start pulse latches a base address and a sample count. Reads
// are then issued in address order, wrapping at the top of the buffer.
// Read data (one cycle of RAM latency) lands in a 2-entry FIFO whose head
// register drives m_valid/m_data directly. A read is only issued when the
// FIFO is certain to have room for its data when that data arrives.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle playback request (ignored while busy or done)
//   base_addr  : first buffer address, sampled with start
//   length     : sample count, sampled with start, clamped to 2**ADDR_W
//   busy       : high from the cycle after an accepted start through done
//   done       : one-cycle completion pulse
//   ram_enb    : buffer read enable
//   ram_addrb  : buffer read address
//   ram_dob    : buffer read data, valid the cycle after ram_enb
//   m_valid    : outgoing sample valid
//   m_data     : outgoing sample (registered)
//   m_ready    : downstream accept
// ---------------------------------------------------------------------------
module tx_bram_reader #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              ram_enb,
   output logic [ADDR_W-1:0] ram_addrb,
   input  logic [DATA_W-1:0] ram_dob,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rd_left_q;    // reads still to issue this run
   logic [CNT_W-1:0]  tx_left_q;    // transfers still to complete this run
   logic              dv_q;         // ram_dob carries a sample issued last cycle
   logic              tail_valid_q;
   logic [DATA_W-1:0] tail_data_q;

   logic              start_ok;
   logic              accept_run;
   logic [CNT_W-1:0]  len_clamped;
   logic              pop;
   logic [1:0]        fill;
   logic              credit_ok;
   logic              last_tx;

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      start_ok    = start & ~busy & ~done;
      len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
      accept_run  = (state_q == IDLE) && start_ok && (len_clamped != '0);
      pop         = m_valid & m_ready;
      // Samples already owed to the FIFO: stored entries plus the read whose
      // data is on ram_dob now. A new read lands two edges later, so it is
      // safe when this total, less a pop this cycle, leaves a free slot.
      fill        = 2'(m_valid) + 2'(tail_valid_q) + 2'(dv_q);
      credit_ok   = pop ? (fill < 2'd3) : (fill < 2'd2);
      last_tx     = pop && (tx_left_q == CNT_W'(1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and read enable
   always_comb begin
      state_d = state_q;
      ram_enb = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept_run) state_d = RUN;
         end
         RUN: begin
            if (credit_ok) begin
               ram_enb = 1'b1;
               if (rd_left_q == CNT_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_tx) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Run bookkeeping, address generation, status flags
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of code order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addrb <= '0;
         rd_left_q <= '0;
         tx_left_q <= '0;
         dv_q      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         dv_q <= ram_enb;
         if (accept_run) begin
            ram_addrb <= base_addr;
            rd_left_q <= len_clamped;
         end else if (ram_enb) begin
            ram_addrb <= ram_addrb + ADDR_W'(1);   // wraps at the buffer top
            rd_left_q <= rd_left_q - CNT_W'(1);
         end

         if (accept_run)  tx_left_q <= len_clamped;
         else if (pop)    tx_left_q <= tx_left_q - CNT_W'(1);

         done <= ((state_q == IDLE) && start_ok && (len_clamped == '0)) ||
                 ((state_q == DRAIN) && last_tx);

         // busy covers the done cycle, then drops
         if (accept_run) busy <= 1'b1;
         else if (done)  busy <= 1'b0;
      end
   end

   // Two-entry FIFO: m_data/m_valid is the head, tail_* the second slot.
   // Credit control guarantees a push never meets a full FIFO without a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid      <= 1'b0;
         m_data       <= '0;
         tail_valid_q <= 1'b0;
         tail_data_q  <= '0;
      end else if (m_valid && !pop) begin
         if (!tail_valid_q && dv_q) begin
            tail_valid_q <= 1'b1;
            tail_data_q  <= ram_dob;
         end
      end else if (tail_valid_q) begin
         m_valid      <= 1'b1;
         m_data       <= tail_data_q;
         tail_valid_q <= dv_q;
         tail_data_q  <= ram_dob;
      end else begin
         m_valid <= dv_q;
         if (dv_q) m_data <= ram_dob;
      end
   end

endmodule
